datapath_control_unit: RTL and testbench

- Hardwired control FSM that sequences the single-bus Datapath through instruction fetch and execute.
- Drives every tristate-out, register-in, ALU-select and memory strobe that a testbench currently drives by hand.
- Sits beside the Datapath. It reads the IR output and a memory-ready flag, and runs one instruction per pass through T0..T5.

---
 rtl/datapath_control_unit_if.sv | 50 +++++
 rtl/datapath_control_unit.sv | 175 +++++++++++++++++
 tb/tb_datapath_control_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/datapath_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : datapath_control_unit_if
// Purpose  : Control/status bundle between the hardwired control unit and
//            the single-bus datapath (IR, memory ready, run control, strobes).
// Revision : 1.0
// ============================================================================
interface datapath_control_unit_if #(
    parameter int OPW = 5
);
    logic [31:0]    IR;
    logic           Mem_ready;
    logic           Stop;
    logic           Start;

    logic           PCout;
    logic           Zlowout;
    logic           MDRout;
    logic           Rout;
    logic           Gra;
    logic           Grb;
    logic           Grc;
    logic           PCin;
    logic           MARin;
    logic           MDRin;
    logic           IRin;
    logic           Yin;
    logic           Zin;
    logic           Rin;
    logic           IncPC;
    logic           Read;
    logic [OPW-1:0] ALU_op;
    logic           Run;
    logic           Illegal;

    modport master (
        input  IR, Mem_ready, Stop, Start,
        output PCout, Zlowout, MDRout, Rout, Gra, Grb, Grc,
        output PCin, MARin, MDRin, IRin, Yin, Zin, Rin,
        output IncPC, Read, ALU_op, Run, Illegal
    );

    modport slave (
        output IR, Mem_ready, Stop, Start,
        input  PCout, Zlowout, MDRout, Rout, Gra, Grb, Grc,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin,
        input  IncPC, Read, ALU_op, Run, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/datapath_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : datapath_control_unit
// Purpose  : Hardwired T0..T5 fetch/execute sequencer for the single-bus
//            datapath, with memory wait, halt/resume and illegal-op flagging.
// Revision : 1.0
// ============================================================================
module datapath_control_unit #(
    parameter int OPW         = 5,
    parameter int RST_PC_HOLD = 1
) (
    input  wire                      Clock,
    input  wire                      Resetn,
    datapath_control_unit_if.master  bus
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    // A hold of zero still needs one edge to leave RST.
    localparam int HOLD_LAST = (RST_PC_HOLD > 0) ? RST_PC_HOLD - 1 : 0;
    localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [OPW-1:0]    w_opcode;
    logic              w_alu_two;
    logic              w_alu_one;
    logic              w_alu;
    logic              w_nop;
    logic              w_halt;
    logic              unused_ir_fields;

    assign w_opcode         = bus.IR[31 -: OPW];
    assign unused_ir_fields = ^bus.IR[31-OPW:0];

    always_comb begin
        w_alu_two = 1'b0;
        w_alu_one = 1'b0;
        case (w_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: w_alu_two = 1'b1;
            OP_NEG, OP_NOT:         w_alu_one = 1'b1;
            default: ;
        endcase
    end

    assign w_alu  = w_alu_two | w_alu_one;
    assign w_nop  = (w_opcode == OP_NOP);
    assign w_halt = (w_opcode == OP_HALT);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= ST_RST;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (r_hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        r_state <= ST_T0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_T0: r_state <= ST_T1;
                ST_T1: if (bus.Mem_ready) r_state <= ST_T2;
                ST_T2: r_state <= ST_T3;
                ST_T3: begin
                    if (w_alu)              r_state <= ST_T4;
                    else if (w_halt)        r_state <= ST_HALT;
                    else if (bus.Stop)      r_state <= ST_HALT;
                    else                    r_state <= ST_T0;
                end
                ST_T4: r_state <= ST_T5;
                ST_T5: r_state <= bus.Stop ? ST_HALT : ST_T0;
                ST_HALT: if (bus.Start && !bus.Stop) r_state <= ST_T0;
                default: r_state <= ST_RST;
            endcase
        end
    end

    // Decoded straight from the state so an asynchronous reset clears them at once.
    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Rout    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.PCin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Rin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.ALU_op  = '0;
        bus.Illegal = 1'b0;
        bus.Run     = 1'b0;
        case (r_state)
            ST_T0: begin
                bus.Run   = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            ST_T1: begin
                bus.Run     = 1'b1;
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            ST_T2: begin
                bus.Run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                bus.Run = 1'b1;
                if (w_alu) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                end else if (!w_nop && !w_halt) begin
                    bus.Illegal = 1'b1;
                end
            end
            ST_T4: begin
                bus.Run    = 1'b1;
                bus.Grc    = w_alu_two;
                bus.Grb    = w_alu_one;
                bus.Rout   = 1'b1;
                bus.ALU_op = w_opcode;
                bus.Zin    = 1'b1;
            end
            ST_T5: begin
                bus.Run     = 1'b1;
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_control_unit
// Purpose  : Directed, self-checking sequence for datapath_control_unit.
// Revision : 1.0
// ============================================================================
module tb_datapath_control_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    datapath_control_unit_if #(.OPW(5)) bus ();

    datapath_control_unit #(
        .OPW         (5),
        .RST_PC_HOLD (1)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions of the packed observation vector.
    localparam logic [22:0] B_PCOUT   = 23'h1 << 22;
    localparam logic [22:0] B_ZLOWOUT = 23'h1 << 21;
    localparam logic [22:0] B_MDROUT  = 23'h1 << 20;
    localparam logic [22:0] B_ROUT    = 23'h1 << 19;
    localparam logic [22:0] B_GRA     = 23'h1 << 18;
    localparam logic [22:0] B_GRB     = 23'h1 << 17;
    localparam logic [22:0] B_GRC     = 23'h1 << 16;
    localparam logic [22:0] B_PCIN    = 23'h1 << 15;
    localparam logic [22:0] B_MARIN   = 23'h1 << 14;
    localparam logic [22:0] B_MDRIN   = 23'h1 << 13;
    localparam logic [22:0] B_IRIN    = 23'h1 << 12;
    localparam logic [22:0] B_YIN     = 23'h1 << 11;
    localparam logic [22:0] B_ZIN     = 23'h1 << 10;
    localparam logic [22:0] B_RIN     = 23'h1 << 9;
    localparam logic [22:0] B_INCPC   = 23'h1 << 8;
    localparam logic [22:0] B_READ    = 23'h1 << 7;
    localparam logic [22:0] B_RUN     = 23'h1 << 6;
    localparam logic [22:0] B_ILLEGAL = 23'h1 << 5;

    localparam logic [22:0] E_IDLE = 23'h0;
    localparam logic [22:0] E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [22:0] E_T1   = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [22:0] E_T2   = B_RUN | B_MDROUT | B_IRIN;
    localparam logic [22:0] E_T3A  = B_RUN | B_GRB | B_ROUT | B_YIN;
    localparam logic [22:0] E_T3N  = B_RUN;
    localparam logic [22:0] E_T3I  = B_RUN | B_ILLEGAL;
    localparam logic [22:0] E_T4_AND  = B_RUN | B_GRC | B_ROUT | B_ZIN | 23'b00101;
    localparam logic [22:0] E_T4_SHRA = B_RUN | B_GRC | B_ROUT | B_ZIN | 23'b01000;
    localparam logic [22:0] E_T5   = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;

    function automatic logic [22:0] observe();
        return {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.Gra, bus.Grb,
                bus.Grc, bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin,
                bus.Zin, bus.Rin, bus.IncPC, bus.Read, bus.Run, bus.Illegal,
                bus.ALU_op};
    endfunction

    task automatic check(input string tag, input logic [22:0] expected);
        logic [22:0] observed;
        observed = observe();
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%06h expected=%06h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.IR        = 32'h0;
        bus.Mem_ready = 1'b1;
        bus.Stop      = 1'b0;
        bus.Start     = 1'b0;

        step(); step();
        check("reset_outputs", E_IDLE);
        rst_n = 1'b1;
        check("rst_after_release", E_IDLE);

        // and R1,R2,R3 with memory always ready
        step(); check("and_t0", E_T0);
        step(); check("and_t1", E_T1);
        step(); check("and_t2", E_T2);
        bus.IR = 32'h2891_8000;
        step(); check("and_t3", E_T3A);
        step(); check("and_t4", E_T4_AND);
        step(); check("and_t5", E_T5);
        step(); check("and_back_t0", E_T0);

        // three wait cycles in T1
        bus.Mem_ready = 1'b0;
        step(); check("wait_t1_enter", E_T1);
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("wait_t1_hold%0d", i), E_T1);
        end
        bus.Mem_ready = 1'b1;
        step(); check("wait_t2", E_T2);

        // shra R1,R3,R5 with Stop raised in T4
        bus.IR = 32'h409A_8000;
        step(); check("shra_t3", E_T3A);
        step(); check("shra_t4", E_T4_SHRA);
        bus.Stop = 1'b1;
        step(); check("shra_t5_completes", E_T5);
        step(); check("stop_halt", E_IDLE);
        bus.Stop  = 1'b0;
        bus.Start = 1'b1;
        step(); check("start_t0", E_T0);
        bus.Start = 1'b0;

        // illegal opcode
        step(); check("ill_t1", E_T1);
        step(); check("ill_t2", E_T2);
        bus.IR = 32'hF800_0000;
        step(); check("ill_t3", E_T3I);
        step(); check("ill_next_t0", E_T0);

        // nop
        step(); step();
        bus.IR = 32'hD000_0000;
        step(); check("nop_t3", E_T3N);
        step(); check("nop_next_t0", E_T0);

        // halt instruction, Start held low
        step(); step();
        bus.IR = 32'hD800_0000;
        step(); check("halt_t3", E_T3N);
        step(); check("halt_enter", E_IDLE);
        for (int i = 0; i < 5; i++) begin
            step(); check($sformatf("halt_stay%0d", i), E_IDLE);
        end
        bus.Start = 1'b1;
        step(); check("halt_resume_t0", E_T0);
        bus.Start = 1'b0;

        // asynchronous reset in T4
        step(); step();
        bus.IR = 32'h2891_8000;
        step(); step(); check("pre_reset_t4", E_T4_AND);
        rst_n = 1'b0;
        #1;
        check("async_reset_t4", E_IDLE);
        step();
        rst_n = 1'b1;
        check("rst_hold_again", E_IDLE);
        step(); check("rst_release_t0", E_T0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
